musb_mux_rr_reg: RTL and testbench

- N-input, DATA-wide registered multiplexer with valid/ready handshake on every input and on the output.
- Built-in arbitration picks one requesting channel per cycle, either round-robin or fixed-priority.
- Sits wherever several producers share one consumer: I-/D-port merge into the memory interface, or writeback source merge.
- Adds one register stage, so select logic leaves the critical path.

---
 rtl/musb_mux_rr_reg_pkg.sv | 13 +
 rtl/musb_mux_rr_reg_if.sv | 26 ++
 rtl/musb_mux_rr_reg_arb.sv | 42 ++++
 rtl/musb_mux_rr_reg.sv | 85 ++++++++
 tb/tb_musb_mux_rr_reg.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/musb_mux_rr_reg_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority multiplexer.
// Arbitration mode encodings and the pointer-advance helper live here.
package musb_mux_rr_reg_pkg;

  localparam int MUSB_ARB_RR    = 32'd0;
  localparam int MUSB_ARB_FIXED = 32'd1;

  // Next round-robin pointer: one past the granted channel, wrapping for any channel count.
  function automatic int next_ptr(input int k, input int channels);
    return (k == channels - 32'd1) ? 32'd0 : k + 32'd1;
  endfunction

endpackage

// File: rtl/musb_mux_rr_reg_if.sv
// Handshake bundle for the multiplexer: N producer channels in, one consumer channel out.
interface musb_mux_rr_reg_if #(
  parameter int DATA     = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);

  logic [CHANNELS*DATA-1:0] in_data;
  logic [CHANNELS-1:0]      in_valid;
  logic [CHANNELS-1:0]      in_ready;
  logic [DATA-1:0]          out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

endinterface

// File: rtl/musb_mux_rr_reg_arb.sv
// Combinational arbiter: picks one requester starting the search at ptr (round-robin)
// or at channel 0 (fixed priority). Returns a one-hot grant and its binary index.
module musb_rr_arbiter
  import musb_mux_rr_reg_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  // Rank each channel by its distance from the search start; the lowest-ranked requester wins.
  always_comb begin
    int start_s;
    int rank_s;
    int best_s;
    logic win_s;
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    win_s   = 1'b0;
    rank_s  = 32'd0;
    start_s = mode ? 32'd0 : int'(ptr);
    best_s  = CHANNELS;
    for (int i = 0; i < CHANNELS; i++) begin
      rank_s = (i >= start_s) ? (i - start_s) : (i + CHANNELS - start_s);
      win_s  = req[i] && (rank_s < best_s);
      idx    = win_s ? SEL_W'(i) : idx;
      best_s = win_s ? rank_s : best_s;
    end
    any = (best_s < CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      grant[i] = any && (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/musb_mux_rr_reg.sv
// N-input registered multiplexer with valid/ready on every port and built-in arbitration.
// One output register stage; a new word loads whenever the register is empty or draining.
module musb_mux_rr_reg
  import musb_mux_rr_reg_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = MUSB_ARB_RR
) (
  input logic            clk,
  input logic            rst,
  musb_mux_rr_reg_if.slave bus
);

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("musb_mux_rr_reg: CHANNELS must be in 2..16");
  end
  if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
    $error("musb_mux_rr_reg: SEL_W must equal clog2(CHANNELS)");
  end
  if (MODE != MUSB_ARB_RR && MODE != MUSB_ARB_FIXED) begin : g_bad_mode
    $error("musb_mux_rr_reg: MODE must be 0 (round-robin) or 1 (fixed)");
  end

  logic [CHANNELS-1:0] grant_s;
  logic [SEL_W-1:0]    idx_s;
  logic                any_s;
  logic                load_s;
  logic [DATA-1:0]     sel_data_s;
  logic [DATA-1:0]     out_data_r;
  logic [SEL_W-1:0]    out_sel_r;
  logic                out_valid_r;
  logic [SEL_W-1:0]    ptr_r;

  musb_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr_r),
    .mode  (MODE == MUSB_ARB_FIXED),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  assign load_s       = ~out_valid_r | bus.out_ready;
  // Reset blocks acceptance so no producer believes a word was taken while state is cleared.
  assign bus.in_ready = grant_s & {CHANNELS{load_s & ~rst}};

  // AND-OR data select over the one-hot grant.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data_s = sel_data_s | (bus.in_data[i*DATA +: DATA] & {DATA{grant_s[i]}});
    end
  end

  // Output register and round-robin pointer; empty loads clear valid but keep data/sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else if (load_s) begin
      if (any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_sel_r   <= idx_s;
        if (MODE == MUSB_ARB_RR) begin
          ptr_r <= SEL_W'(next_ptr(int'(idx_s), CHANNELS));
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_musb_mux_rr_reg.sv
// Bench for musb_mux_rr_reg: three instances (4ch round-robin, 4ch fixed, 3ch round-robin)
// checked every cycle against a queue-free behavioural model, plus directed literal checks.
module tb_musb_mux_rr_reg;
  import musb_mux_rr_reg_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  vld  [ND];
  logic [31:0] dat  [ND][4];
  logic        ordy [ND];
  logic [3:0]  rdy  [ND];
  logic        ov   [ND];
  logic [31:0] od   [ND];
  logic [1:0]  os   [ND];

  int tests  = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  musb_mux_rr_reg_if #(.DATA(32), .CHANNELS(4), .SEL_W(2)) if0 ();
  musb_mux_rr_reg_if #(.DATA(32), .CHANNELS(4), .SEL_W(2)) if1 ();
  musb_mux_rr_reg_if #(.DATA(32), .CHANNELS(3), .SEL_W(2)) if2 ();

  assign if0.in_data   = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign if0.in_valid  = vld[0];
  assign if0.out_ready = ordy[0];
  assign rdy[0] = if0.in_ready;
  assign ov[0]  = if0.out_valid;
  assign od[0]  = if0.out_data;
  assign os[0]  = if0.out_sel;

  assign if1.in_data   = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign if1.in_valid  = vld[1];
  assign if1.out_ready = ordy[1];
  assign rdy[1] = if1.in_ready;
  assign ov[1]  = if1.out_valid;
  assign od[1]  = if1.out_data;
  assign os[1]  = if1.out_sel;

  assign if2.in_data   = {dat[2][2], dat[2][1], dat[2][0]};
  assign if2.in_valid  = vld[2][2:0];
  assign if2.out_ready = ordy[2];
  assign rdy[2] = {1'b0, if2.in_ready};
  assign ov[2]  = if2.out_valid;
  assign od[2]  = if2.out_data;
  assign os[2]  = if2.out_sel;

  musb_mux_rr_reg #(.DATA(32), .CHANNELS(4), .SEL_W(2), .MODE(MUSB_ARB_RR))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  musb_mux_rr_reg #(.DATA(32), .CHANNELS(4), .SEL_W(2), .MODE(MUSB_ARB_FIXED))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  musb_mux_rr_reg #(.DATA(32), .CHANNELS(3), .SEL_W(2), .MODE(MUSB_ARB_RR))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic int nch(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  // Scan the channels in circular order from the start point; first requester wins.
  function automatic int pick(input logic [3:0] req, input int p, input int n, input int md);
    int start;
    start = (md == 1) ? 0 : p;
    for (int j = 0; j < n; j++) begin
      int k;
      k = (start + j) % n;
      if (((req >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  // Model state: output register contents and arbitration pointer per instance.
  logic        m_v [ND];
  logic [31:0] m_d [ND];
  logic [1:0]  m_s [ND];
  int          m_p [ND];
  int          mk  [ND];
  logic [3:0]  exp_rdy [ND];

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      mk[d] = pick(vld[d], m_p[d], nch(d), mode_of(d));
      exp_rdy[d] = (!rst && (!m_v[d] || ordy[d]) && mk[d] >= 0) ? (4'b0001 << mk[d]) : 4'b0000;
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_v[d] <= 1'b0;
        m_d[d] <= 32'd0;
        m_s[d] <= 2'd0;
        m_p[d] <= 0;
      end else if (!m_v[d] || ordy[d]) begin
        if (mk[d] >= 0) begin
          m_v[d] <= 1'b1;
          m_d[d] <= dat[d][mk[d]];
          m_s[d] <= 2'(mk[d]);
          if (mode_of(d) == 0) m_p[d] <= (mk[d] + 1) % nch(d);
        end else begin
          m_v[d] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("dut%0d in_ready", d), 32'(rdy[d]), 32'(exp_rdy[d]));
        check($sformatf("dut%0d out_valid", d), 32'(ov[d]), 32'(m_v[d]));
        check($sformatf("dut%0d out_data", d), od[d], m_d[d]);
        check($sformatf("dut%0d out_sel", d), 32'(os[d]), 32'(m_s[d]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Producers hold a word until accepted, then may present a new one or go idle.
  task automatic rand_cycles(input int n);
    logic [3:0] acc [ND];
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) acc[d] = exp_rdy[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < nch(d); c++) begin
          if (acc[d][c] || !vld[d][c]) begin
            vld[d][c] = ($urandom_range(0, 99) < 60);
            dat[d][c] = $urandom;
          end
        end
        ordy[d] = ($urandom_range(0, 99) < 70);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      vld[d]  = 4'b0000;
      ordy[d] = 1'b0;
      for (int c = 0; c < 4; c++) dat[d][c] = 32'd0;
    end
    cyc();
    cyc();
    chk_on = 1'b1;
    vld[0] = 4'b1111;
    #1;
    check("reset in_ready", 32'(rdy[0]), 32'd0);
    check("reset out_valid", 32'(ov[0]), 32'd0);
    check("reset out_data", od[0], 32'd0);
    vld[0] = 4'b0000;

    // Load a word, stall it, then reset asynchronously mid-cycle.
    cyc();
    rst = 1'b0;
    vld[0] = 4'b0001;
    dat[0][0] = 32'hDEADBEEF;
    ordy[0] = 1'b1;
    cyc();
    check("held word valid", 32'(ov[0]), 32'd1);
    check("held word data", od[0], 32'hDEADBEEF);
    ordy[0] = 1'b0;
    vld[0] = 4'b0000;
    cyc();
    check("stalled word data", od[0], 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(ov[0]), 32'd0);
    check("async rst out_data", od[0], 32'd0);
    check("async rst out_sel", 32'(os[0]), 32'd0);
    for (int c = 0; c < 4; c++) dat[0][c] = 32'h10 + 32'(c);
    vld[0] = 4'b1111;
    ordy[0] = 1'b1;
    #1;
    check("in_ready during rst", 32'(rdy[0]), 32'd0);

    // All four request with the consumer always ready: 0,1,2,3,0 back to back.
    cyc();
    rst = 1'b0;
    #1;
    check("first grant ch0", 32'(rdy[0]), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr seq out_valid", 32'(ov[0]), 32'd1);
      check("rr seq out_sel", 32'(os[0]), 32'(i % 4));
      check("rr seq out_data", od[0], 32'h10 + 32'(i % 4));
      check("rr seq in_ready", 32'(rdy[0]), 32'(4'b0001 << ((i + 1) % 4)));
    end

    // Backpressure on channel 2's word; pointer must sit at 3 across the stall.
    vld[0] = 4'b0100;
    dat[0][2] = 32'hA5A5A5A5;
    cyc();
    check("bp load sel", 32'(os[0]), 32'd2);
    ordy[0] = 1'b0;
    vld[0] = 4'b1111;
    repeat (3) begin
      #1;
      check("bp in_ready zero", 32'(rdy[0]), 32'd0);
      cyc();
      check("bp out_valid", 32'(ov[0]), 32'd1);
      check("bp out_data", od[0], 32'hA5A5A5A5);
      check("bp out_sel", 32'(os[0]), 32'd2);
    end
    ordy[0] = 1'b1;
    #1;
    check("bp release in_ready", 32'(rdy[0]), 32'b1000);
    cyc();
    check("bp release sel", 32'(os[0]), 32'd3);
    check("bp release data", od[0], 32'h13);

    // Idle: valid falls one edge after the last word, data/sel retained.
    vld[0] = 4'b0000;
    repeat (2) begin
      cyc();
      check("idle out_valid", 32'(ov[0]), 32'd0);
      check("idle out_data", od[0], 32'h13);
      check("idle out_sel", 32'(os[0]), 32'd3);
    end

    // Fixed priority: channel 1 beats channel 3 until it drops.
    vld[1] = 4'b1010;
    dat[1][1] = 32'h111;
    dat[1][3] = 32'h333;
    ordy[1] = 1'b1;
    repeat (4) begin
      cyc();
      check("fixed ch1 wins", 32'(os[1]), 32'd1);
      check("fixed ch1 data", od[1], 32'h111);
    end
    vld[1] = 4'b1000;
    cyc();
    check("fixed ch3 after drop", 32'(os[1]), 32'd3);
    check("fixed ch3 data", od[1], 32'h333);
    vld[1] = 4'b0000;

    // Three channels: pointer reaches 2 then wraps to 0, never selecting 3.
    vld[2] = 4'b0010;
    dat[2][1] = 32'h21;
    ordy[2] = 1'b1;
    cyc();
    check("wrap setup sel", 32'(os[2]), 32'd1);
    vld[2] = 4'b0101;
    dat[2][0] = 32'h20;
    dat[2][2] = 32'h22;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("wrap sel", 32'(os[2]), (i % 2 == 0) ? 32'd2 : 32'd0);
      check("wrap data", od[2], (i % 2 == 0) ? 32'h22 : 32'h20);
    end
    vld[2] = 4'b0000;

    // Random traffic on all three instances with one asynchronous reset pulse.
    rand_cycles(1500);
    #2;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rand_cycles(1500);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
